// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - shared memory port arbiter for instruction fetch and load/store
//
// Purpose: arbitrates a single memory port between the instruction fetch
// unit (IF) and the load/store unit (LS). At most one transaction is
// outstanding. LS wins over IF when both request in the same idle cycle.
// A redirect (jump_en) cancels delivery of an in-flight fetch response.
//
// Ports:
//   clk, rst                    clock, synchronous active-high reset
//   stop_all                    freeze: blocks new grants only
//   jump_en                     redirect: drops the outstanding fetch response
//   if_req, if_addr             fetch request and address
//   ls_req, ls_wen, ls_addr,
//   ls_wdata, ls_wmask          load/store request and store fields
//   mem_req, mem_addr,
//   mem_wdata, mem_wen,
//   mem_wmask                   shared port request (registered)
//   mem_gnt                     port accepted the request this cycle
//   mem_rvalid, mem_rdata       port response
//   if_rvalid, if_rdata         fetch response (1-cycle pulse, data held)
//   ls_rvalid, ls_rdata         LSU response (1-cycle pulse, data held)
//   pause_mem                   pipeline stall while an LSU access is unfinished

module mem_port_arbiter (
  input  logic        clk,
  input  logic        rst,
  input  logic        stop_all,
  input  logic        jump_en,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  input  logic        ls_req,
  input  logic        ls_wen,
  input  logic [31:0] ls_addr,
  input  logic [31:0] ls_wdata,
  input  logic [7:0]  ls_wmask,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic        mem_wen,
  output logic [7:0]  mem_wmask,
  input  logic        mem_gnt,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata,
  output logic        if_rvalid,
  output logic [31:0] if_rdata,
  output logic        ls_rvalid,
  output logic [31:0] ls_rdata,
  output logic        pause_mem
);

  typedef enum logic [1:0] {IDLE, REQ, RESP} state_t;
  typedef enum logic {OWN_IF, OWN_LS} owner_t;

  state_t state;
  owner_t owner;
  logic   drop;

  assign pause_mem = ls_req & ~ls_rvalid;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      owner     <= OWN_IF;
      drop      <= 1'b0;
      mem_req   <= 1'b0;
      mem_addr  <= 32'h0;
      mem_wdata <= 32'h0;
      mem_wen   <= 1'b0;
      mem_wmask <= 8'h0;
      if_rvalid <= 1'b0;
      if_rdata  <= 32'h0;
      ls_rvalid <= 1'b0;
      ls_rdata  <= 32'h0;
    end else begin
      // Response strobes are single-cycle pulses.
      if_rvalid <= 1'b0;
      ls_rvalid <= 1'b0;

      case (state)
        IDLE: begin
          drop <= 1'b0;
          if (!stop_all && ls_req) begin
            mem_addr  <= ls_addr;
            mem_wdata <= ls_wdata;
            mem_wen   <= ls_wen;
            mem_wmask <= ls_wmask;
            mem_req   <= 1'b1;
            owner     <= OWN_LS;
            state     <= REQ;
          end else if (!stop_all && if_req && !jump_en) begin
            mem_addr  <= if_addr;
            mem_wdata <= 32'h0;
            mem_wen   <= 1'b0;
            mem_wmask <= 8'h0;
            mem_req   <= 1'b1;
            owner     <= OWN_IF;
            state     <= REQ;
          end
        end

        REQ: begin
          if (owner == OWN_IF && jump_en) begin
            drop <= 1'b1;
          end
          // Request and fields stay stable until the port accepts them.
          if (mem_gnt) begin
            mem_req <= 1'b0;
            state   <= RESP;
          end
        end

        RESP: begin
          if (owner == OWN_IF && jump_en) begin
            drop <= 1'b1;
          end
          if (mem_rvalid) begin
            state <= IDLE;
            drop  <= 1'b0;
            if (owner == OWN_LS) begin
              ls_rvalid <= 1'b1;
              ls_rdata  <= mem_rdata;
            end else if (!drop && !jump_en) begin
              // A redirect in the same cycle as the response also cancels it.
              if_rvalid <= 1'b1;
              if_rdata  <= mem_rdata;
            end
          end
        end

        default: begin
          state   <= IDLE;
          mem_req <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - self-checking bench for mem_port_arbiter
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        stop_all = 1'b0;
  logic        jump_en = 1'b0;
  logic        if_req = 1'b0;
  logic [31:0] if_addr = 32'h0;
  logic        ls_req = 1'b0;
  logic        ls_wen = 1'b0;
  logic [31:0] ls_addr = 32'h0;
  logic [31:0] ls_wdata = 32'h0;
  logic [7:0]  ls_wmask = 8'h0;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_wen;
  logic [7:0]  mem_wmask;
  logic        mem_gnt = 1'b0;
  logic        mem_rvalid = 1'b0;
  logic [31:0] mem_rdata = 32'h0;
  logic        if_rvalid;
  logic [31:0] if_rdata;
  logic        ls_rvalid;
  logic [31:0] ls_rdata;
  logic        pause_mem;

  always #5 clk = ~clk;

  mem_port_arbiter dut (
    .clk        (clk),
    .rst        (rst),
    .stop_all   (stop_all),
    .jump_en    (jump_en),
    .if_req     (if_req),
    .if_addr    (if_addr),
    .ls_req     (ls_req),
    .ls_wen     (ls_wen),
    .ls_addr    (ls_addr),
    .ls_wdata   (ls_wdata),
    .ls_wmask   (ls_wmask),
    .mem_req    (mem_req),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_wen    (mem_wen),
    .mem_wmask  (mem_wmask),
    .mem_gnt    (mem_gnt),
    .mem_rvalid (mem_rvalid),
    .mem_rdata  (mem_rdata),
    .if_rvalid  (if_rvalid),
    .if_rdata   (if_rdata),
    .ls_rvalid  (ls_rvalid),
    .ls_rdata   (ls_rdata),
    .pause_mem  (pause_mem)
  );

  typedef struct packed {
    logic        is_ls;
    logic [31:0] data;
  } exp_t;

  exp_t exp_q[$];
  int   errors = 0;
  int   checks = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard: every response pulse must match the oldest expected entry.
  always @(negedge clk) begin
    exp_t e;
    if (!rst && (if_rvalid || ls_rvalid)) begin
      if (exp_q.size() == 0) begin
        check("unexpected_rvalid", {30'h0, if_rvalid, ls_rvalid}, 32'h0);
      end else begin
        e = exp_q.pop_front();
        check("resp_ls_rvalid", {31'h0, ls_rvalid}, {31'h0, e.is_ls});
        check("resp_if_rvalid", {31'h0, if_rvalid}, {31'h0, !e.is_ls});
        check("resp_data", e.is_ls ? ls_rdata : if_rdata, e.data);
      end
    end
  end

  task automatic check_all_zero(input string tag);
    check({tag, "_mem_req"},   {31'h0, mem_req}, 32'h0);
    check({tag, "_mem_addr"},  mem_addr, 32'h0);
    check({tag, "_mem_wdata"}, mem_wdata, 32'h0);
    check({tag, "_mem_wen"},   {31'h0, mem_wen}, 32'h0);
    check({tag, "_mem_wmask"}, {24'h0, mem_wmask}, 32'h0);
    check({tag, "_if_rvalid"}, {31'h0, if_rvalid}, 32'h0);
    check({tag, "_ls_rvalid"}, {31'h0, ls_rvalid}, 32'h0);
    check({tag, "_if_rdata"},  if_rdata, 32'h0);
    check({tag, "_ls_rdata"},  ls_rdata, 32'h0);
  endtask

  // Grants the current request, then returns the given response data.
  // Returns one tick after the response, when the rvalid pulse is visible.
  task automatic grant_and_respond(input logic [31:0] data, input logic push, input logic is_ls);
    exp_t e;
    mem_gnt = 1'b1;
    tick();
    mem_gnt = 1'b0;
    check("resp_state_mem_req_low", {31'h0, mem_req}, 32'h0);
    mem_rvalid = 1'b1;
    mem_rdata  = data;
    if (push) begin
      e.is_ls = is_ls;
      e.data  = data;
      exp_q.push_back(e);
    end
    tick();
    mem_rvalid = 1'b0;
  endtask

  initial begin
    // Reset
    tick();
    tick();
    check_all_zero("reset");
    check("reset_pause_mem", {31'h0, pause_mem}, 32'h0);
    rst = 1'b0;
    tick();

    // Single fetch with minimum latency
    if_req  = 1'b1;
    if_addr = 32'h8000_0000;
    tick();
    check("fetch_mem_req", {31'h0, mem_req}, 32'h1);
    check("fetch_mem_addr", mem_addr, 32'h8000_0000);
    check("fetch_mem_wen", {31'h0, mem_wen}, 32'h0);
    check("fetch_mem_wmask", {24'h0, mem_wmask}, 32'h0);
    grant_and_respond(32'h0000_0413, 1'b1, 1'b0);
    check("fetch_latency_if_rvalid", {31'h0, if_rvalid}, 32'h1);
    if_req = 1'b0;
    tick();
    check("fetch_pulse_width", {31'h0, if_rvalid}, 32'h0);
    check("fetch_rdata_hold", if_rdata, 32'h0000_0413);
    check("fetch_idle_no_req", {31'h0, mem_req}, 32'h0);

    // mem_rvalid while idle is ignored
    mem_rvalid = 1'b1;
    mem_rdata  = 32'h1234_5678;
    tick();
    mem_rvalid = 1'b0;
    tick();
    check("idle_rvalid_ignored", {31'h0, if_rvalid | ls_rvalid}, 32'h0);

    // Contention: LS first, then fetch back-to-back
    if_req  = 1'b1;
    if_addr = 32'h8000_0004;
    ls_req  = 1'b1;
    ls_wen  = 1'b0;
    ls_addr = 32'h8000_1000;
    #1;
    check("contend_pause_mem", {31'h0, pause_mem}, 32'h1);
    tick();
    check("contend_ls_first_req", {31'h0, mem_req}, 32'h1);
    check("contend_ls_first_addr", mem_addr, 32'h8000_1000);
    check("contend_ls_wen", {31'h0, mem_wen}, 32'h0);
    check("contend_pause_in_req", {31'h0, pause_mem}, 32'h1);
    grant_and_respond(32'h1111_2222, 1'b1, 1'b1);
    check("contend_ls_rvalid", {31'h0, ls_rvalid}, 32'h1);
    check("contend_pause_released", {31'h0, pause_mem}, 32'h0);
    ls_req = 1'b0;
    tick();
    check("contend_fetch_next_req", {31'h0, mem_req}, 32'h1);
    check("contend_fetch_next_addr", mem_addr, 32'h8000_0004);
    grant_and_respond(32'h3333_4444, 1'b1, 1'b0);
    check("contend_fetch_rvalid", {31'h0, if_rvalid}, 32'h1);
    if_req = 1'b0;
    tick();

    // Store with 5 cycles of backpressure, stray rvalid and jump_en in REQ
    ls_req   = 1'b1;
    ls_wen   = 1'b1;
    ls_addr  = 32'h8000_2000;
    ls_wdata = 32'hDEAD_BEEF;
    ls_wmask = 8'h0F;
    tick();
    ls_addr  = 32'h0;
    ls_wdata = 32'h0;
    check("store_mem_addr", mem_addr, 32'h8000_2000);
    check("store_mem_wdata", mem_wdata, 32'hDEAD_BEEF);
    check("store_mem_wen", {31'h0, mem_wen}, 32'h1);
    check("store_mem_wmask", {24'h0, mem_wmask}, 32'h0000_000F);
    for (int i = 0; i < 5; i++) begin
      mem_rvalid = (i == 1);
      jump_en    = (i == 2);
      tick();
      mem_rvalid = 1'b0;
      jump_en    = 1'b0;
      check("backpressure_mem_req", {31'h0, mem_req}, 32'h1);
      check("backpressure_mem_addr", mem_addr, 32'h8000_2000);
      check("backpressure_mem_wdata", mem_wdata, 32'hDEAD_BEEF);
    end
    grant_and_respond(32'hA5A5_A5A5, 1'b1, 1'b1);
    check("store_ls_rvalid", {31'h0, ls_rvalid}, 32'h1);
    ls_req = 1'b0;
    ls_wen = 1'b0;
    tick();

    // Flush: jump_en while fetch in RESP drops the response
    if_req  = 1'b1;
    if_addr = 32'h8000_0008;
    tick();
    mem_gnt = 1'b1;
    tick();
    mem_gnt = 1'b0;
    jump_en = 1'b1;
    if_req  = 1'b0;
    tick();
    jump_en = 1'b0;
    tick();
    mem_rvalid = 1'b1;
    mem_rdata  = 32'h0000_0BAD;
    tick();
    mem_rvalid = 1'b0;
    check("flush_if_rvalid_low", {31'h0, if_rvalid}, 32'h0);
    check("flush_if_rdata_hold", if_rdata, 32'h3333_4444);
    if_req  = 1'b1;
    if_addr = 32'h8000_000C;
    tick();
    check("flush_back_to_idle_req", {31'h0, mem_req}, 32'h1);
    check("flush_back_to_idle_addr", mem_addr, 32'h8000_000C);
    grant_and_respond(32'h5555_6666, 1'b1, 1'b0);
    if_req = 1'b0;
    tick();

    // Freeze: stop_all blocks grants only
    stop_all = 1'b1;
    if_req   = 1'b1;
    if_addr  = 32'h8000_0010;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("freeze_no_req", {31'h0, mem_req}, 32'h0);
    end
    stop_all = 1'b0;
    tick();
    check("unfreeze_req", {31'h0, mem_req}, 32'h1);
    check("unfreeze_addr", mem_addr, 32'h8000_0010);
    stop_all = 1'b1;
    grant_and_respond(32'h7777_8888, 1'b1, 1'b0);
    check("freeze_inflight_completes", {31'h0, if_rvalid}, 32'h1);
    if_req   = 1'b0;
    stop_all = 1'b0;
    tick();

    // Reset in RESP, late response discarded
    ls_req   = 1'b1;
    ls_addr  = 32'h8000_3000;
    ls_wdata = 32'h0;
    tick();
    mem_gnt = 1'b1;
    tick();
    mem_gnt = 1'b0;
    rst     = 1'b1;
    tick();
    rst    = 1'b0;
    ls_req = 1'b0;
    check_all_zero("midreset");
    mem_rvalid = 1'b1;
    mem_rdata  = 32'h9999_0000;
    tick();
    mem_rvalid = 1'b0;
    check("late_rvalid_ls", {31'h0, ls_rvalid}, 32'h0);
    tick();
    check("late_rvalid_ls_next", {31'h0, ls_rvalid}, 32'h0);
    check("late_rvalid_if_next", {31'h0, if_rvalid}, 32'h0);
    check("late_rvalid_no_req", {31'h0, mem_req}, 32'h0);

    tick();
    check("scoreboard_drained", exp_q.size(), 32'h0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 Parameter: none; address and data widths SHALL be 32 bits, write mask 8 bits (byte strobes of 64-bit bus lane unused bits tied 0).
REQ-002 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 stop_all  input  1  global freeze; blocks new grants.
REQ-005 jump_en  input  1  redirect; cancels outstanding fetch delivery.
REQ-006 if_req  input  1  fetch request, held until if_rvalid or jump_en.
REQ-007 if_addr  input  32  fetch address.
REQ-008 ls_req  input  1  load/store request, held until ls_rvalid.
REQ-009 ls_wen  input  1  1 = store, 0 = load.
REQ-010 ls_addr / ls_wdata  input  32 / 32  LSU address, store data.
REQ-011 ls_wmask  input  8  store byte mask.
REQ-012 mem_req  output  1  shared-port request.
REQ-013 mem_addr / mem_wdata  output  32 / 32  port address, write data.
REQ-014 mem_wen  output  1; mem_wmask  output  8.
REQ-015 mem_gnt  input  1  port accepted request this cycle.
REQ-016 mem_rvalid  input  1; mem_rdata  input  32  port response.
REQ-017 if_rvalid  output  1; if_rdata  output  32  fetch response.
REQ-018 ls_rvalid  output  1; ls_rdata  output  32  LSU response.
REQ-019 pause_mem  output  1  pipeline stall while LSU access is unfinished.

Function
REQ-020 FSM states IDLE, REQ, RESP; one outstanding transaction max; owner register (IF/LS) and drop flag.
REQ-021 IDLE: if stop_all=0 and ls_req=1, SHALL latch LS address/data/mask/wen, owner=LS, go REQ.
REQ-022 IDLE: else if stop_all=0, if_req=1, jump_en=0, SHALL latch if_addr, mem_wen=0, mask=0, owner=IF, go REQ.
REQ-023 LSU SHALL win over IF when both request in the same IDLE cycle.
REQ-024 REQ: mem_req=1 with latched fields held stable; on mem_gnt=1 go RESP; mem_req SHALL NOT drop before mem_gnt.
REQ-025 RESP: mem_req=0; on mem_rvalid=1 go IDLE, register mem_rdata into owner's rdata and pulse owner's rvalid for exactly 1 cycle next cycle.
REQ-026 Latency: request seen in IDLE at cycle N -> mem_req from N+1; with mem_gnt at N+1 and mem_rvalid at N+2, rvalid at N+3.
REQ-027 jump_en=1 while owner=IF in REQ or RESP SHALL set drop; transaction completes on port, if_rvalid suppressed, drop cleared on return to IDLE.
REQ-028 jump_en does not affect LS-owned transactions.
REQ-029 stop_all SHALL only gate IDLE grants; in-flight transactions complete normally.
REQ-030 A new grant SHALL be possible in the IDLE cycle in which an rvalid pulse is output (back-to-back).
REQ-031 pause_mem = ls_req & ~ls_rvalid, combinational.
REQ-032 mem_rvalid in IDLE or REQ SHALL be ignored.
REQ-033 if_rdata/ls_rdata SHALL hold last value between pulses.

Reset
REQ-034 rst=1 SHALL force IDLE, owner=IF, drop=0, all outputs 0 (mem_*, rvalid, rdata) on the next edge, aborting any transaction mid-flight; responses arriving after reset are discarded.

Verification
REQ-035 Fetch: if_req=1, if_addr=0x80000000; gnt 1 cycle later, rvalid+rdata=0x00000413 next -> if_rvalid pulse, if_rdata=0x00000413, latency per REQ-026.
REQ-036 Contention: if_req and ls_req (load 0x80001000) same cycle -> LS served first, pause_mem=1 until ls_rvalid, then fetch served next.
REQ-037 Store: ls_wen=1, addr 0x80002000, wdata 0xDEADBEEF, mask 0x0F -> mem fields exact, mem_wen=1, ls_rvalid pulse on response.
REQ-038 Flush: fetch in RESP, jump_en pulse -> mem_rvalid arrives, if_rvalid stays 0, FSM back to IDLE.
REQ-039 Backpressure/freeze: mem_gnt low 5 cycles -> mem_req and fields stable; stop_all=1 in IDLE with if_req -> no mem_req until stop_all=0.
REQ-040 Reset mid-transaction in RESP -> all outputs 0, late mem_rvalid produces no rvalid.
